// File: rtl/countdown_timer_param.sv
// Parametrised BCD countdown timer with load, start/restart, pause/resume,
// an expired flag, a timed beep pulse and registered seven-segment outputs.
module countdown_timer_param #(
    parameter int CLK_HZ         = 50000000,
    parameter int TICK_HZ        = 1,
    parameter int DIGITS         = 2,
    parameter int START_VAL      = 30,
    parameter int BEEP_CYCLES    = 25000000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  load_en,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic [7*DIGITS-1:0]   segs,
    output logic                  running,
    output logic                  expired,
    output logic                  beep
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(BEEP_CYCLES + 1);
    localparam int TW  = 4 * DIGITS;
    localparam int SW  = 7 * DIGITS;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    function automatic logic [TW-1:0] to_bcd(input int v);
        logic [TW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    function automatic logic [TW-1:0] clamp_bcd(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    // Decrement by one; a zero digit wraps to 9 and borrows from the digit above.
    function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    function automatic logic [SW-1:0] encode(input logic [TW-1:0] v);
        logic [SW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[7*i +: 7] = seg7(v[4*i +: 4]) ^ {7{SEG_ACTIVE_LOW != 0}};
        end
        return r;
    endfunction

    localparam logic [TW-1:0] START_BCD = to_bcd(START_VAL);
    localparam logic [TW-1:0] BCD_ONE   = TW'(1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
    localparam logic [BW-1:0] BEEP_LEN  = BW'(BEEP_CYCLES);

    logic [1:0]    state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [TW-1:0] preset, preset_n;
    logic [TW-1:0] count_p0, count_n;
    logic [SW-1:0] segs_p1;
    logic [BW-1:0] beep_cnt, beep_cnt_n;
    logic          beep_n;
    logic          tick;

    always_comb begin
        state_n    = state;
        presc_n    = presc;
        preset_n   = preset;
        count_n    = count_p0;
        beep_cnt_n = beep_cnt;
        beep_n     = 1'b0;
        tick       = (presc == PRE_LAST);
        if (load_en) begin
            preset_n   = clamp_bcd(load_val);
            count_n    = clamp_bcd(load_val);
            presc_n    = '0;
            state_n    = IDLE;
            beep_cnt_n = '0;
        end else if (start) begin
            count_n = preset;
            presc_n = '0;
            if (preset != '0) begin
                state_n    = RUN;
                beep_cnt_n = '0;
            end else begin
                state_n    = DONE;
                beep_cnt_n = BEEP_LEN;
            end
        end else begin
            case (state)
                RUN: begin
                    // Pause wins over a coinciding tick, so the held prescaler never skips.
                    if (pause) begin
                        state_n = PAUSED;
                    end else if (tick) begin
                        presc_n = '0;
                        if (count_p0 == BCD_ONE) begin
                            count_n    = '0;
                            state_n    = DONE;
                            beep_cnt_n = BEEP_LEN;
                        end else begin
                            count_n = bcd_dec(count_p0);
                        end
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end
                PAUSED: begin
                    if (!pause) state_n = RUN;
                end
                DONE: begin
                    if (beep_cnt != '0) begin
                        beep_n     = 1'b1;
                        beep_cnt_n = beep_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p0: control state and count; stage p1: segment patterns from the count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            presc    <= '0;
            preset   <= START_BCD;
            count_p0 <= START_BCD;
            beep_cnt <= '0;
            beep     <= 1'b0;
            running  <= 1'b0;
            expired  <= 1'b0;
            segs_p1  <= encode(START_BCD);
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            preset   <= preset_n;
            count_p0 <= count_n;
            beep_cnt <= beep_cnt_n;
            beep     <= beep_n;
            running  <= (state_n == RUN);
            expired  <= (state_n == DONE);
            segs_p1  <= encode(count_p0);
        end
    end

    assign time_bcd = count_p0;
    assign segs     = segs_p1;

endmodule

// File: tb/tb_countdown_timer_param.sv
// Scoreboard bench for countdown_timer_param: the driver queues expected outputs
// tagged with a clock cycle, and a monitor compares them when that cycle arrives.
module tb_countdown_timer_param;

    logic        clock;
    logic        reset;
    logic        start;
    logic        pause;
    logic        load_en;
    logic [7:0]  load_val;
    logic [7:0]  time_bcd;
    logic [13:0] segs;
    logic        running;
    logic        expired;
    logic        beep;

    countdown_timer_param #(
        .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .START_VAL(12),
        .BEEP_CYCLES(5), .SEG_ACTIVE_LOW(0)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .load_en(load_en), .load_val(load_val), .time_bcd(time_bcd),
        .segs(segs), .running(running), .expired(expired), .beep(beep)
    );

    localparam logic [13:0] S12 = {7'h06, 7'h5B};
    localparam logic [13:0] S10 = {7'h06, 7'h3F};
    localparam logic [13:0] S09 = {7'h3F, 7'h6F};
    localparam logic [13:0] S93 = {7'h6F, 7'h4F};

    typedef struct {
        string       name;
        int          cyc;
        bit          imm;
        logic [7:0]  t;
        logic        r;
        logic        e;
        logic        b;
        bit          cs;
        logic [13:0] sg;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   s, e, l;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // c < 0 means "check right now" (asynchronous reset); otherwise check at cycle c.
    task automatic push(input string nm, input int c, input logic [7:0] t,
                        input logic r, input logic ex, input logic b,
                        input bit cs = 1'b0, input logic [13:0] sg = '0);
        exp_t x;
        x.name = nm; x.cyc = c; x.imm = (c < 0);
        x.t = t; x.r = r; x.e = ex; x.b = b; x.cs = cs; x.sg = sg;
        sb.push_back(x);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        exp_t x;
        bit   bad;
        forever begin
            @(negedge clock or chk_ev);
            while (sb.size() > 0 && (sb[0].imm || sb[0].cyc <= cyc)) begin
                x   = sb.pop_front();
                n_vec++;
                bad = (time_bcd !== x.t) || (running !== x.r) || (expired !== x.e) ||
                      (beep !== x.b) || (x.cs && (segs !== x.sg)) ||
                      (!x.imm && x.cyc < cyc);
                if (bad) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got time=%h run=%b exp=%b beep=%b segs=%h, want time=%h run=%b exp=%b beep=%b segs=%h (segs checked=%0d)",
                             x.name, cyc, time_bcd, running, expired, beep, segs,
                             x.t, x.r, x.e, x.b, x.sg, x.cs);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; load_en = 1'b0; load_val = 8'h00;

        // Asynchronous reset mid-clock, then release.
        #12 reset = 1'b0;
        #1;
        push("reset_async", -1, 8'h12, 0, 0, 0, 1, S12);
        -> chk_ev;
        n_vec++;
        if (time_bcd !== 8'h12) begin
            n_bad++;
            $display("FAIL reset_direct: time=%h want 12", time_bcd);
        end
        if (running !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_direct: running=%b want 0", running);
        end
        if (expired !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_direct: expired=%b want 0", expired);
        end
        if (beep !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_direct: beep=%b want 0", beep);
        end
        if (segs !== S12) begin
            n_bad++;
            $display("FAIL reset_direct: segs=%h want %h", segs, S12);
        end
        wait_to(cyc + 3);
        reset = 1'b1;
        push("reset_segs", cyc + 1, 8'h12, 0, 0, 0, 1, S12);
        wait_to(cyc + 2);

        // Full countdown from 12 with borrow, expiry and beep length.
        start = 1'b1;
        s = cyc + 1;
        e = s + 120;
        push("run_start",    s,       8'h12, 1, 0, 0);
        push("run_pre_tick", s + 9,   8'h12, 1, 0, 0);
        push("run_first",    s + 10,  8'h11, 1, 0, 0);
        push("run_borrow",   s + 30,  8'h09, 1, 0, 0, 1, S10);
        push("run_segs09",   s + 31,  8'h09, 1, 0, 0, 1, S09);
        push("run_last1",    s + 119, 8'h01, 1, 0, 0);
        push("done_entry",   e,       8'h00, 0, 1, 0);
        push("beep_first",   e + 1,   8'h00, 0, 1, 1);
        push("beep_last",    e + 5,   8'h00, 0, 1, 1);
        push("beep_off",     e + 6,   8'h00, 0, 1, 0);
        push("done_hold",    e + 20,  8'h00, 0, 1, 0);
        wait_to(s);
        start = 1'b0;
        wait_to(e + 20);

        // Pause after 15 cycles for 40 cycles, then resume.
        start = 1'b1;
        s = cyc + 1;
        push("p_restart",   s,      8'h12, 1, 0, 0);
        push("p_enter",     s + 16, 8'h11, 0, 0, 0);
        push("p_frozen",    s + 55, 8'h11, 0, 0, 0);
        push("p_resume",    s + 56, 8'h11, 1, 0, 0);
        push("p_pre_tick",  s + 60, 8'h11, 1, 0, 0);
        push("p_tick",      s + 61, 8'h10, 1, 0, 0);
        wait_to(s);
        start = 1'b0;
        wait_to(s + 15);
        pause = 1'b1;
        wait_to(s + 55);
        pause = 1'b0;
        wait_to(s + 61);

        // Load with digit clamp, then run from the clamped preset.
        load_en = 1'b1; load_val = 8'hA3;
        l = cyc + 1;
        push("load_clamp", l,     8'h93, 0, 0, 0);
        push("load_segs",  l + 1, 8'h93, 0, 0, 0, 1, S93);
        wait_to(l);
        load_en = 1'b0;
        wait_to(l + 3);
        start = 1'b1;
        s = cyc + 1;
        push("ld_start",    s,      8'h93, 1, 0, 0);
        push("ld_pre_tick", s + 9,  8'h93, 1, 0, 0);
        push("ld_tick",     s + 10, 8'h92, 1, 0, 0);
        wait_to(s);
        start = 1'b0;
        wait_to(s + 10);

        // Zero preset: start goes straight to DONE with a full beep.
        load_en = 1'b1; load_val = 8'h00;
        l = cyc + 1;
        push("zero_load", l, 8'h00, 0, 0, 0);
        wait_to(l);
        load_en = 1'b0; start = 1'b1;
        s = cyc + 1;
        push("zero_done",  s,     8'h00, 0, 1, 0);
        push("zero_beep1", s + 1, 8'h00, 0, 1, 1);
        push("zero_beep5", s + 5, 8'h00, 0, 1, 1);
        push("zero_quiet", s + 6, 8'h00, 0, 1, 0);
        wait_to(s);
        start = 1'b0;
        wait_to(s + 6);

        // load_en and start together: load wins, timer stays idle.
        load_en = 1'b1; start = 1'b1; load_val = 8'h45;
        l = cyc + 1;
        push("prio_load", l,     8'h45, 0, 0, 0);
        push("prio_idle", l + 3, 8'h45, 0, 0, 0);
        wait_to(l);
        load_en = 1'b0; start = 1'b0;
        wait_to(l + 3);

        // Reset while the beep is sounding.
        load_en = 1'b1; load_val = 8'h01;
        l = cyc + 1;
        push("one_load", l, 8'h01, 0, 0, 0);
        wait_to(l);
        load_en = 1'b0; start = 1'b1;
        s = cyc + 1;
        push("one_start", s,      8'h01, 1, 0, 0);
        push("one_done",  s + 10, 8'h00, 0, 1, 0);
        push("one_beep",  s + 11, 8'h00, 0, 1, 1);
        wait_to(s);
        start = 1'b0;
        wait_to(s + 12);
        #3 reset = 1'b0;
        #1;
        push("reset_mid", -1, 8'h12, 0, 0, 0, 1, S12);
        -> chk_ev;
        n_vec++;
        if (time_bcd !== 8'h12) begin
            n_bad++;
            $display("FAIL reset_mid_direct: time=%h want 12", time_bcd);
        end
        if (running !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_direct: running=%b want 0", running);
        end
        if (expired !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_direct: expired=%b want 0", expired);
        end
        if (beep !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_direct: beep=%b want 0", beep);
        end
        if (segs !== S12) begin
            n_bad++;
            $display("FAIL reset_mid_direct: segs=%h want %h", segs, S12);
        end
        wait_to(cyc + 2);
        reset = 1'b1; start = 1'b1;
        s = cyc + 1;
        push("post_reset_start", s, 8'h12, 1, 0, 0, 1, S12);
        wait_to(s);
        start = 1'b0;

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clock);
        #1;
        while (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: never checked, cycle now %0d, required at cycle %0d",
                     sb[0].name, cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
